serial_packet_receiver: RTL and testbench

- Deserializer for the NeXT peripheral serial link, the receive-side counterpart of the packet sender.
- Accepts the same frame format the sender emits: one start bit (1), then 40 data bits MSB first, then an inter-packet gap of zeros.
- Hands each complete 40-bit packet to the downstream command decoder over a valid/ready interface.
- Flags framing errors and overruns.

---
 rtl/nextasic_link_pkg.sv | 17 +
 rtl/packet_hold_reg.sv | 47 ++++
 rtl/serial_packet_receiver.sv | 123 ++++++++++++
 tb/tb_serial_packet_receiver.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nextasic_link_pkg.sv
// Shared definitions for the NeXT peripheral serial link (sender and receiver sides).
package nextasic_link_pkg;

  localparam int PACKET_W = 40;
  localparam int FRAME_W  = PACKET_W + 1;
  localparam int GAP_BITS = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } rx_state_t;

  localparam logic [PACKET_W-1:0] AUDIO_REQ_PKT      = 40'h0700000000;
  localparam logic [PACKET_W-1:0] AUDIO_UNDERRUN_PKT = 40'h0f00000000;

endpackage

// File: rtl/packet_hold_reg.sv
// One-entry valid/ready holding register with overrun detection.
// Handshake: data transfers out when valid & ready are both high at posedge;
// data is held stable while valid is high and not popped.
module packet_hold_reg #(
  parameter int W = 40
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_push_data,
  input  logic         i_ready,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output logic         o_overrun
);
  import nextasic_link_pkg::*;

  logic [W-1:0] r_data;
  logic         r_valid;
  logic         r_overrun;

  // Load on push when empty or popping; a push into a full, unpopped entry is dropped and flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (i_push) begin
        if (!r_valid || i_ready) begin
          r_data  <= i_push_data;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/serial_packet_receiver.sv
// Receive-side deserializer for the NeXT peripheral serial link.
// Frame: start bit (1), PACKET_W data bits MSB first, then at least GAP_BITS zeros.
// The completed word is handed to a one-entry holding register one clock after
// the last data bit is sampled.
module serial_packet_receiver #(
  parameter int PACKET_W = nextasic_link_pkg::PACKET_W,
  parameter int GAP_BITS = nextasic_link_pkg::GAP_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sin,
  output logic [PACKET_W-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                framing_error,
  output logic                overrun,
  output logic                busy,
  output logic [1:0]          o_dbg_state
);
  import nextasic_link_pkg::*;

  localparam int BW = $clog2(PACKET_W);
  localparam int GW = $clog2(GAP_BITS + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(PACKET_W - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_BITS - 1);

  rx_state_t           r_state;
  rx_state_t           w_next_state;
  logic [PACKET_W-1:0] r_shift;
  logic [BW-1:0]       r_bit_cnt;
  logic [GW-1:0]       r_gap_cnt;
  logic                r_push;
  logic                r_framing_error;
  logic                w_last_bit;
  logic                w_gap_violation;

  // Next-state logic: start bit opens a frame, last data bit enters the gap, a clean gap returns to idle.
  always_comb begin
    w_next_state    = r_state;
    w_last_bit      = 1'b0;
    w_gap_violation = 1'b0;
    case (r_state)
      IDLE: begin
        if (sin) w_next_state = SHIFT;
      end
      SHIFT: begin
        if (r_bit_cnt == BIT_LAST) begin
          w_last_bit   = 1'b1;
          w_next_state = GAP;
        end
      end
      GAP: begin
        if (sin) begin
          w_gap_violation = 1'b1;
        end else if (r_gap_cnt == GAP_LAST) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Shift register, bit/gap counters, and the registered push and error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift         <= '0;
      r_bit_cnt       <= '0;
      r_gap_cnt       <= '0;
      r_push          <= 1'b0;
      r_framing_error <= 1'b0;
    end else begin
      // The full word sits in r_shift after the last data bit, so pushing
      // one clock later presents it to the holding register unchanged.
      r_push          <= w_last_bit;
      r_framing_error <= w_gap_violation;
      case (r_state)
        IDLE: begin
          r_bit_cnt <= '0;
          r_gap_cnt <= '0;
        end
        SHIFT: begin
          r_shift   <= {r_shift[PACKET_W-2:0], sin};
          r_bit_cnt <= r_bit_cnt + BW'(1);
          r_gap_cnt <= '0;
        end
        GAP: begin
          // An early one restarts the zero count; the receiver only
          // resynchronises after GAP_BITS consecutive zeros.
          if (sin || (r_gap_cnt == GAP_LAST)) r_gap_cnt <= '0;
          else                                r_gap_cnt <= r_gap_cnt + GW'(1);
        end
        default: begin
          r_bit_cnt <= '0;
          r_gap_cnt <= '0;
        end
      endcase
    end
  end

  packet_hold_reg #(
    .W(PACKET_W)
  ) u_hold (
    .clk         (clk),
    .rst         (rst),
    .i_push      (r_push),
    .i_push_data (r_shift),
    .i_ready     (out_ready),
    .o_data      (out_data),
    .o_valid     (out_valid),
    .o_overrun   (overrun)
  );

  assign framing_error = r_framing_error;
  assign busy          = (r_state != IDLE);
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_serial_packet_receiver.sv
// Directed bench for serial_packet_receiver with a queue-based scoreboard.
module tb_serial_packet_receiver;

  localparam int W = 40;

  logic         clk;
  logic         rst;
  logic         sin;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         framing_error;
  logic         overrun;
  logic         busy;
  logic [1:0]   o_dbg_state;

  serial_packet_receiver dut (
    .clk           (clk),
    .rst           (rst),
    .sin           (sin),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .framing_error (framing_error),
    .overrun       (overrun),
    .busy          (busy),
    .o_dbg_state   (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int valid_cycles = 0;
  int rise_cyc = -1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  // Samples at negedge: inputs change at posedge+3, outputs at posedge, so
  // valid&ready seen here is exactly the handshake taken at the next posedge.
  logic         prev_valid = 1'b0;
  logic         prev_ready = 1'b0;
  logic [W-1:0] prev_data  = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (framing_error) fe_cnt++;
      if (overrun) ov_cnt++;
      if (framing_error || overrun) begin
        checks++;
        if (framing_error && overrun) begin
          failures++;
          $display("FAIL err_coincide fe=%0b ov=%0b required=not_both", framing_error, overrun);
        end
      end
      if (out_valid) valid_cycles++;
      if (out_valid && !prev_valid) rise_cyc = cyc;
      if (prev_valid && !prev_ready && out_valid) begin
        checks++;
        if (out_data !== prev_data) begin
          failures++;
          $display("FAIL data_stable got=%h expected=%h", out_data, prev_data);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_pop got=%h expected=none", out_data);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          if (out_data !== e) begin
            failures++;
            $display("FAIL pop_data got=%h expected=%h", out_data, e);
          end
        end
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_data  = out_data;
    end
  end

  // ---------------- driver tasks ----------------
  // Each call presents one bit, waits for the sampling edge, and returns at posedge+3.
  task automatic drive_bit(input logic b);
    sin = b;
    @(posedge clk);
    #3;
  endtask

  task automatic send_frame(input logic [W-1:0] d);
    drive_bit(1'b1);
    for (int i = W - 1; i >= 0; i--) drive_bit(d[i]);
  endtask

  task automatic send_zeros(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b0);
  endtask

  // ---------------- stimulus ----------------
  localparam logic [W-1:0] PKT_REQ   = 40'h0700000000;
  localparam logic [W-1:0] PKT_A     = 40'hD999999991;
  localparam logic [W-1:0] PKT_B     = 40'h0f00000000;
  localparam logic [W-1:0] PKT_C     = 40'h123456789A;
  localparam logic [W-1:0] PKT_D     = 40'hA5C3E1F00F;
  localparam logic [W-1:0] PKT_ZERO  = 40'h0000000000;
  localparam logic [W-1:0] PKT_PART  = 40'hFFFFFFFFFF;

  initial begin
    int start_cyc;
    int fe0;
    int ov0;
    int vc0;
    int waited;

    rst = 1'b1;
    sin = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("rst_out_data", 64'(out_data), 64'h0);
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_framing_error", 64'(framing_error), 64'h0);
    check("rst_overrun", 64'(overrun), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_state", 64'(o_dbg_state), 64'h0);
    rst = 1'b0;
    send_zeros(2);

    // Test 1: single frame, latency and one-cycle valid
    out_ready = 1'b1;
    fe0 = fe_cnt; ov0 = ov_cnt; vc0 = valid_cycles;
    exp_q.push_back(PKT_REQ);
    drive_bit(1'b1);
    start_cyc = cyc;
    for (int i = W - 1; i >= 0; i--) drive_bit(PKT_REQ[i]);
    send_zeros(5);
    check("t1_latency", 64'(rise_cyc - start_cyc), 64'd41);
    check("t1_valid_cycles", 64'(valid_cycles - vc0), 64'd1);
    check("t1_no_fe", 64'(fe_cnt - fe0), 64'd0);
    check("t1_no_ov", 64'(ov_cnt - ov0), 64'd0);
    check("t1_idle", 64'(busy), 64'h0);

    // Test 2: back-to-back frames with minimum gap
    fe0 = fe_cnt;
    exp_q.push_back(PKT_A);
    send_frame(PKT_A);
    send_zeros(3);
    exp_q.push_back(PKT_B);
    send_frame(PKT_B);
    send_zeros(5);
    check("t2_no_fe", 64'(fe_cnt - fe0), 64'd0);
    check("t2_drained", 64'(exp_q.size()), 64'd0);

    // Test 3: backpressure, second frame dropped with overrun
    out_ready = 1'b0;
    ov0 = ov_cnt;
    exp_q.push_back(PKT_A);
    send_frame(PKT_A);
    send_zeros(3);
    send_frame(PKT_B);
    send_zeros(3);
    check("t3_overrun_once", 64'(ov_cnt - ov0), 64'd1);
    check("t3_valid_held", 64'(out_valid), 64'h1);
    check("t3_data_held", 64'(out_data), 64'(PKT_A));
    out_ready = 1'b1;
    drive_bit(1'b0);
    out_ready = 1'b0;
    check("t3_valid_dropped", 64'(out_valid), 64'h0);

    // Test 4: pop of A coincides with push of B
    ov0 = ov_cnt;
    exp_q.push_back(PKT_A);
    send_frame(PKT_A);
    send_zeros(3);
    exp_q.push_back(PKT_B);
    send_frame(PKT_B);
    out_ready = 1'b1;
    drive_bit(1'b0);
    out_ready = 1'b0;
    check("t4_valid_stays", 64'(out_valid), 64'h1);
    check("t4_data_new", 64'(out_data), 64'(PKT_B));
    send_zeros(2);
    check("t4_no_overrun", 64'(ov_cnt - ov0), 64'd0);
    out_ready = 1'b1;
    send_zeros(3);
    check("t4_drained", 64'(exp_q.size()), 64'd0);

    // Test 5: early start bit in the gap
    fe0 = fe_cnt;
    exp_q.push_back(PKT_A);
    send_frame(PKT_A);
    drive_bit(1'b1);
    send_zeros(3);
    check("t5_fe_once", 64'(fe_cnt - fe0), 64'd1);
    check("t5_one_packet", 64'(exp_q.size()), 64'd0);
    exp_q.push_back(PKT_C);
    send_frame(PKT_C);
    send_zeros(4);
    check("t5_resync", 64'(exp_q.size()), 64'd0);

    // Test 6: async reset mid-frame
    drive_bit(1'b1);
    for (int i = W - 1; i >= W - 20; i--) drive_bit(PKT_PART[i]);
    check("t6_busy_before", 64'(busy), 64'h1);
    rst = 1'b1;
    #1;
    check("t6_rst_data", 64'(out_data), 64'h0);
    check("t6_rst_valid", 64'(out_valid), 64'h0);
    check("t6_rst_busy", 64'(busy), 64'h0);
    check("t6_rst_errs", 64'({framing_error, overrun}), 64'h0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    send_zeros(2);
    exp_q.push_back(PKT_D);
    send_frame(PKT_D);
    send_zeros(4);

    // Test 7: all-zero payload is a real packet
    exp_q.push_back(PKT_ZERO);
    send_frame(PKT_ZERO);
    send_zeros(4);

    waited = 0;
    while (exp_q.size() != 0 && waited < 100) begin
      @(posedge clk);
      waited++;
    end
    #3;
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    check("final_idle", 64'(busy), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
